// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - round-robin arbiter sharing one mem_manager port between NUM_REQ requesters
// Optional build macro MEM_ARB_TIMEOUT_EN: bounds the WAIT_DONE stall and adds the sticky timeout_err output.
module mem_request_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int PAUSE_WAIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wren,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_write,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           data_read,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  input  logic                        controller_ready,
  input  logic                        mem_pause,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_wren,
  output logic                        mem_rden,
  output logic [DATA_W-1:0]           mem_data_write,
  input  logic [DATA_W-1:0]           mem_data_read
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int CW = $clog2(PAUSE_WAIT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t              state, next_state;
  logic [2:0]          ptr;
  logic [2:0]          win;
  logic                found;
  logic                grant_ok;
  logic [7:0]          req_pad;
  logic [7:0]          wren_pad;
  logic [7:0]          ack_onehot;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                lat_wren;
  logic [CW-1:0]       wait_cnt;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0]         to_cnt;
  logic                to_hit;
  logic                to_fire;
`endif

  assign req_pad    = 8'(req);
  assign wren_pad   = 8'(req_wren);
  assign ack_onehot = 8'd1 << grant_id;
  assign grant_ok   = controller_ready && !mem_pause && found;
`ifdef MEM_ARB_TIMEOUT_EN
  assign to_fire    = mem_pause && (to_cnt == 16'hFFFE);
`endif

  // Round-robin search: first set request above the last winner, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_pad[3'(idx)]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic for the grant / strobe / pause handshake sequence.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (grant_ok) next_state = S_ISSUE;
      S_ISSUE:      next_state = S_WAIT_START;
      S_WAIT_START: begin
        if (mem_pause)                         next_state = S_WAIT_DONE;
        else if (wait_cnt == CW'(PAUSE_WAIT)) next_state = S_RESPOND;
      end
      S_WAIT_DONE: begin
        if (!mem_pause) next_state = S_RESPOND;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (to_fire) next_state = S_RESPOND;
`endif
      end
      S_RESPOND:    next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  // Datapath: latch at grant, strobe at issue, return data and ack at respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack            <= '0;
      data_read      <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      mem_address    <= '0;
      mem_wren       <= 1'b0;
      mem_rden       <= 1'b0;
      mem_data_write <= '0;
      ptr            <= 3'(NUM_REQ - 1);
      lat_addr       <= '0;
      lat_data       <= '0;
      lat_wren       <= 1'b0;
      wait_cnt       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt         <= '0;
      to_hit         <= 1'b0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      ack      <= '0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            grant_id <= win;
            busy     <= 1'b1;
            lat_addr <= req_address[int'(win)*ADDR_W +: ADDR_W];
            lat_data <= req_data_write[int'(win)*DATA_W +: DATA_W];
            lat_wren <= wren_pad[win];
          end
        end
        S_ISSUE: begin
          mem_address    <= lat_addr;
          mem_data_write <= lat_data;
          mem_wren       <= lat_wren;
          mem_rden       <= !lat_wren;
          wait_cnt       <= '0;
        end
        S_WAIT_START: begin
          wait_cnt <= wait_cnt + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt   <= '0;
`endif
        end
        S_WAIT_DONE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          if (mem_pause) to_cnt <= to_cnt + 16'd1;
          if (to_fire)   to_hit <= 1'b1;
`endif
        end
        S_RESPOND: begin
          ack  <= ack_onehot[NUM_REQ-1:0];
          ptr  <= grant_id;
          busy <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          to_hit <= 1'b0;
          if (to_hit) begin
            data_read   <= DATA_W'(32'hDEADBEEF);
            timeout_err <= 1'b1;
          end else if (!lat_wren) begin
            data_read <= mem_data_read;
          end
`else
          if (!lat_wren) data_read <= mem_data_read;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - directed self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int PW      = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wren;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_data_write;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         data_read;
  logic [2:0]                grant_id;
  logic                      busy;
  logic                      controller_ready;
  logic                      mem_pause;
  logic [ADDR_W-1:0]         mem_address;
  logic                      mem_wren;
  logic                      mem_rden;
  logic [DATA_W-1:0]         mem_data_write;
  logic [DATA_W-1:0]         mem_data_read;
`ifdef MEM_ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wr_pulses  = 0;
  int rd_pulses  = 0;
  int ack_pulses = 0;
  logic [31:0]       last_mdr = '0;
  logic [ADDR_W-1:0] strobe_addr = '0;
  logic [DATA_W-1:0] strobe_data = '0;

  always #5 clk = ~clk;

  mem_request_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAUSE_WAIT(PW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_wren         (req_wren),
    .req_address      (req_address),
    .req_data_write   (req_data_write),
    .ack              (ack),
    .data_read        (data_read),
    .grant_id         (grant_id),
    .busy             (busy),
    .controller_ready (controller_ready),
    .mem_pause        (mem_pause),
    .mem_address      (mem_address),
    .mem_wren         (mem_wren),
    .mem_rden         (mem_rden),
    .mem_data_write   (mem_data_write),
    .mem_data_read    (mem_data_read)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_wren) begin wr_pulses++; strobe_addr = mem_address; strobe_data = mem_data_write; end
    if (mem_rden) begin rd_pulses++; strobe_addr = mem_address; end
    if (ack != '0) ack_pulses++;
    last_mdr      = mem_data_read;
    mem_data_read = 32'hC0DE_0000 + 32'(cyc);
  endtask

  task automatic wait_ack(input int max, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ack == '0 && lat < max);
    check("ack_seen", 64'(|ack), 64'd1);
  endtask

  task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_address[i*ADDR_W +: ADDR_W]    = a;
    req_data_write[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},        64'(ack), 64'd0);
    check({pfx, "_data_read"},  64'(data_read), 64'd0);
    check({pfx, "_grant_id"},   64'(grant_id), 64'd0);
    check({pfx, "_busy"},       64'(busy), 64'd0);
    check({pfx, "_mem_addr"},   64'(mem_address), 64'd0);
    check({pfx, "_mem_wren"},   64'(mem_wren), 64'd0);
    check({pfx, "_mem_rden"},   64'(mem_rden), 64'd0);
    check({pfx, "_mem_wdata"},  64'(mem_data_write), 64'd0);
  endtask

  initial begin
    int lat;
    int snap;
    int g;
    reset = 1'b1; req = '0; req_wren = '0; req_address = '0; req_data_write = '0;
    controller_ready = 1'b0; mem_pause = 1'b0; mem_data_read = '0;
    tick(); tick();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Write from requester 0 with a 5-cycle pause.
    controller_ready = 1'b1;
    set_slot(0, 18'd200000, 32'h0A0A0B0B);
    req_wren = 3'b001; req = 3'b001;
    tick();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_grant", 64'(grant_id), 64'd0);
    set_slot(0, 18'd5, 32'h11111111);
    tick();
    check("t1_wren", 64'(mem_wren), 64'd1);
    check("t1_rden", 64'(mem_rden), 64'd0);
    check("t1_addr", 64'(mem_address), 64'd200000);
    check("t1_wdata", 64'(mem_data_write), 64'h0A0A0B0B);
    mem_pause = 1'b1;
    repeat (5) tick();
    check("t1_ack_during_pause", 64'(ack_pulses), 64'd0);
    mem_pause = 1'b0;
    tick();
    check("t1_ack_not_early", 64'(ack), 64'd0);
    tick();
    check("t1_ack", 64'(ack), 64'b001);
    check("t1_busy_clr", 64'(busy), 64'd0);
    check("t1_rdata_hold", 64'(data_read), 64'd0);
    req = '0;
    tick();
    check("t1_ack_once", 64'(ack_pulses), 64'd1);
    check("t1_wr_once", 64'(wr_pulses), 64'd1);

    // controller_ready low blocks grants.
    controller_ready = 1'b0;
    req_wren = 3'b000;
    set_slot(1, 18'd1234, 32'h0);
    req = 3'b010;
    snap = wr_pulses + rd_pulses;
    repeat (20) begin
      tick();
      check("t3_busy_not_ready", 64'(busy), 64'd0);
    end
    check("t3_no_strobe", 64'(wr_pulses + rd_pulses), 64'(snap));
    controller_ready = 1'b1;
    tick();
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_grant", 64'(grant_id), 64'd1);
    wait_ack(50, lat);
    check("t3_ack", 64'(ack), 64'b010);
    check("t3_rdata", 64'(data_read), 64'(last_mdr));
    req = '0;

    // Read with mem_pause never rising.
    set_slot(2, 18'd77, 32'h0);
    req = 3'b100;
    tick();
    check("t4_grant", 64'(grant_id), 64'd2);
    wait_ack(50, lat);
    check("t4_latency", 64'(lat), 64'(PW + 3));
    check("t4_ack", 64'(ack), 64'b100);
    check("t4_rdata", 64'(data_read), 64'(last_mdr));
    check("t4_addr", 64'(strobe_addr), 64'd77);
    req = '0;

    // Reset during WAIT_DONE.
    req = 3'b010;
    tick();
    check("t5_grant", 64'(grant_id), 64'd1);
    tick();
    check("t5_rden", 64'(mem_rden), 64'd1);
    mem_pause = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("t5");
    reset = 1'b0; mem_pause = 1'b0; req = '0;
    snap = ack_pulses;
    repeat (10) tick();
    check("t5_no_ack", 64'(ack_pulses), 64'(snap));

    // All requesters reading continuously: order 0,1,2,0.
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 18'(200000 + i), 32'h0);
    req_wren = 3'b000;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int exp_id;
      exp_id = k % NUM_REQ;
      g = 0;
      do begin tick(); g++; end while (!busy && g < 20);
      check("t2_busy", 64'(busy), 64'd1);
      check("t2_grant", 64'(grant_id), 64'(exp_id));
      wait_ack(50, lat);
      check("t2_ack", 64'(ack), 64'(1 << exp_id));
      check("t2_rdata", 64'(data_read), 64'(last_mdr));
      check("t2_addr", 64'(strobe_addr), 64'(200000 + exp_id));
    end
    req = '0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Pause stuck high: timeout path.
    req = 3'b001;
    tick();
    tick();
    mem_pause = 1'b1;
    wait_ack(70000, lat);
    req = '0;
    check("to_ack", 64'(ack), 64'b001);
    check("to_rdata", 64'(data_read), 64'hDEADBEEF);
    check("to_err", 64'(timeout_err), 64'd1);
    mem_pause = 1'b0;
    repeat (5) tick();
    check("to_err_sticky", 64'(timeout_err), 64'd1);
    reset = 1'b1;
    tick();
    check("to_err_reset", 64'(timeout_err), 64'd0);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
